// File: rtl/door_motor_seq_if.sv
// Button/limit inputs and motor/status outputs of the door sequencer.
// master drives the board-side inputs; slave is the sequencer itself.
interface door_motor_seq_if;
    logic       press;
    logic       lim_open;
    logic       lim_closed;
    logic       open_cw;
    logic       open_ccw;
    logic [2:0] state;
    logic       fault;

    modport master (
        output press, lim_open, lim_closed,
        input  open_cw, open_ccw, state, fault
    );

    modport slave (
        input  press, lim_open, lim_closed,
        output open_cw, open_ccw, state, fault
    );
endinterface

// File: rtl/door_motor_seq.sv
// Push-button door drive sequencer: debounced press, reversal dead-time, travel timeout, sticky fault.
// Define DOOR_AUTO_CLOSE_EN to auto-close after HOLD_CYC cycles in OPEN.
module door_motor_seq #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int DEAD_CYC     = 3,
    parameter int TRAVEL_MAX   = 64,
    parameter int HOLD_CYC     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    door_motor_seq_if.slave  bus
);
    // state   | meaning
    // CLOSED  | at rest, door shut
    // OPENING | cw motor on, waiting for lim_open
    // OPEN    | at rest, door open
    // CLOSING | ccw motor on, waiting for lim_closed
    // DEAD    | both motors off before reversing to stored target
    // FAULT   | sticky, motors off until a press
    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_DEAD    = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    localparam int DBW     = $clog2(DEBOUNCE_CYC + 1);
    localparam int CNT_A   = (TRAVEL_MAX > HOLD_CYC) ? TRAVEL_MAX : HOLD_CYC;
    localparam int CNT_TOP = (CNT_A > DEAD_CYC) ? CNT_A : DEAD_CYC;
    localparam int CW      = $clog2(CNT_TOP + 1);

    logic           press_s1, press_s2, press_db, press_db_q;
    logic [DBW-1:0] db_cnt;
    logic           press_evt;

    state_t         state_q, state_next;
    logic           target_open, target_open_next;
    logic [CW-1:0]  state_cnt;
    logic           open_cw_q, open_ccw_q, fault_q;
    logic           timeout, dead_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_s1   <= 1'b0;
            press_s2   <= 1'b0;
            press_db   <= 1'b0;
            press_db_q <= 1'b0;
            db_cnt     <= '0;
        end else begin
            press_s1   <= bus.press;
            press_s2   <= press_s1;
            press_db_q <= press_db;
            if (press_s2 == press_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DEBOUNCE_CYC)) begin
                press_db <= ~press_db;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press_evt = press_db & ~press_db_q;

    // One dwell counter serves travel timeout, dead-time and hold; it restarts on every state change.
    assign timeout   = (state_cnt == CW'(TRAVEL_MAX - 1));
    assign dead_done = (state_cnt == CW'(DEAD_CYC - 1));

    always_comb begin
        state_next       = state_q;
        target_open_next = target_open;
        if (bus.lim_open && bus.lim_closed && state_q != ST_FAULT) begin
            state_next = ST_FAULT;
        end else begin
            case (state_q)
                ST_CLOSED: begin
                    if (press_evt) state_next = ST_OPENING;
                end
                ST_OPENING: begin
                    if (bus.lim_open) begin
                        state_next = ST_OPEN;
                    end else if (timeout) begin
                        state_next = ST_FAULT;
                    end else if (press_evt) begin
                        state_next       = ST_DEAD;
                        target_open_next = 1'b0;
                    end
                end
                ST_OPEN: begin
                    if (press_evt) begin
                        state_next = ST_CLOSING;
`ifdef DOOR_AUTO_CLOSE_EN
                    end else if (state_cnt == CW'(HOLD_CYC - 1)) begin
                        state_next = ST_CLOSING;
`endif
                    end
                end
                ST_CLOSING: begin
                    if (bus.lim_closed) begin
                        state_next = ST_CLOSED;
                    end else if (timeout) begin
                        state_next = ST_FAULT;
                    end else if (press_evt) begin
                        state_next       = ST_DEAD;
                        target_open_next = 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (dead_done) begin
                        if (target_open) state_next = bus.lim_open ? ST_OPEN : ST_OPENING;
                        else             state_next = bus.lim_closed ? ST_CLOSED : ST_CLOSING;
                    end
                end
                ST_FAULT: begin
                    if (press_evt) begin
                        state_next       = ST_DEAD;
                        target_open_next = 1'b0;
                    end
                end
                default: state_next = ST_CLOSED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLOSED;
            target_open <= 1'b0;
            state_cnt   <= '0;
            open_cw_q   <= 1'b0;
            open_ccw_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_next;
            target_open <= target_open_next;
            if (state_next != state_q)  state_cnt <= '0;
            else if (state_cnt != '1)   state_cnt <= state_cnt + 1'b1;
            open_cw_q   <= (state_next == ST_OPENING);
            open_ccw_q  <= (state_next == ST_CLOSING);
            fault_q     <= (state_next == ST_FAULT);
        end
    end

    assign bus.state    = state_q;
    assign bus.open_cw  = open_cw_q;
    assign bus.open_ccw = open_ccw_q;
    assign bus.fault    = fault_q;
endmodule

// File: tb/tb_door_motor_seq.sv
// Directed bench for door_motor_seq; define DOOR_AUTO_CLOSE_EN to exercise auto-close.
module tb_door_motor_seq;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    door_motor_seq_if bus ();

    door_motor_seq #(
        .DEBOUNCE_CYC (4),
        .DEAD_CYC     (3),
        .TRAVEL_MAX   (64),
        .HOLD_CYC     (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press held long enough to debounce; the state has moved when this returns.
    task automatic do_press;
        bus.press = 1'b1;
        tick(8);
        bus.press = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.press = 1'b0; bus.lim_open = 1'b0; bus.lim_closed = 1'b0;
        tick(3);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
        checks++; if (bus.open_cw !== 1'b0) begin errors++; $display("FAIL reset_cw got %b want 0", bus.open_cw); end
        checks++; if (bus.open_ccw !== 1'b0) begin errors++; $display("FAIL reset_ccw got %b want 0", bus.open_ccw); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", bus.fault); end
        rst_n = 1'b1;
        tick(1);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL post_reset_state got %0d want 0", bus.state); end
    endtask

    task automatic test_open_close;
        bus.press = 1'b1;
        tick(7);
        checks++; if (bus.state !== 3'd0 || bus.open_cw !== 1'b0) begin errors++; $display("FAIL open_early state=%0d cw=%b want 0 0", bus.state, bus.open_cw); end
        tick(1);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL open_e7_state got %0d want 1", bus.state); end
        checks++; if (bus.open_cw !== 1'b1 || bus.open_ccw !== 1'b0) begin errors++; $display("FAIL open_e7_en cw=%b ccw=%b want 1 0", bus.open_cw, bus.open_ccw); end
        tick(2);
        bus.press = 1'b0;
        bus.lim_open = 1'b1;
        tick(1);
        bus.lim_open = 1'b0;
        checks++; if (bus.state !== 3'd2 || bus.open_cw !== 1'b0) begin errors++; $display("FAIL lim_open state=%0d cw=%b want 2 0", bus.state, bus.open_cw); end
        tick(10);
        do_press;
        checks++; if (bus.state !== 3'd3 || bus.open_ccw !== 1'b1 || bus.open_cw !== 1'b0) begin errors++; $display("FAIL open_to_closing state=%0d cw=%b ccw=%b want 3 0 1", bus.state, bus.open_cw, bus.open_ccw); end
        bus.lim_closed = 1'b1;
        tick(1);
        bus.lim_closed = 1'b0;
        checks++; if (bus.state !== 3'd0 || bus.open_ccw !== 1'b0) begin errors++; $display("FAIL lim_closed state=%0d ccw=%b want 0 0", bus.state, bus.open_ccw); end
        tick(8);
    endtask

    task automatic test_glitch;
        for (int g = 0; g < 3; g++) begin
            bus.press = 1'b1;
            for (int c = 0; c < 8; c++) begin
                if (c == 2) bus.press = 1'b0;
                tick(1);
                checks++;
                if (bus.state !== 3'd0 || bus.open_cw !== 1'b0 || bus.open_ccw !== 1'b0) begin
                    errors++; $display("FAIL glitch state=%0d cw=%b ccw=%b want 0 0 0", bus.state, bus.open_cw, bus.open_ccw);
                end
            end
        end
    endtask

    task automatic test_reverse;
        do_press;
        checks++; if (bus.state !== 3'd1 || bus.open_cw !== 1'b1) begin errors++; $display("FAIL rev_opening state=%0d cw=%b want 1 1", bus.state, bus.open_cw); end
        tick(8);
        do_press;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.state !== 3'd4 || bus.open_cw !== 1'b0 || bus.open_ccw !== 1'b0) begin
                errors++; $display("FAIL dead_cycle%0d state=%0d cw=%b ccw=%b want 4 0 0", i, bus.state, bus.open_cw, bus.open_ccw);
            end
            tick(1);
        end
        checks++; if (bus.state !== 3'd3 || bus.open_ccw !== 1'b1 || bus.open_cw !== 1'b0) begin errors++; $display("FAIL dead_to_closing state=%0d cw=%b ccw=%b want 3 0 1", bus.state, bus.open_cw, bus.open_ccw); end
        bus.lim_closed = 1'b1;
        tick(1);
        bus.lim_closed = 1'b0;
        checks++; if (bus.state !== 3'd0 || bus.open_ccw !== 1'b0) begin errors++; $display("FAIL rev_closed state=%0d ccw=%b want 0 0", bus.state, bus.open_ccw); end
        tick(8);
    endtask

    task automatic test_timeout;
        do_press;
        tick(63);
        checks++; if (bus.state !== 3'd1 || bus.open_cw !== 1'b1) begin errors++; $display("FAIL travel_last state=%0d cw=%b want 1 1", bus.state, bus.open_cw); end
        tick(1);
        checks++; if (bus.state !== 3'd5 || bus.fault !== 1'b1) begin errors++; $display("FAIL timeout state=%0d fault=%b want 5 1", bus.state, bus.fault); end
        checks++; if (bus.open_cw !== 1'b0 || bus.open_ccw !== 1'b0) begin errors++; $display("FAIL timeout_en cw=%b ccw=%b want 0 0", bus.open_cw, bus.open_ccw); end
        tick(5);
        checks++; if (bus.state !== 3'd5 || bus.fault !== 1'b1) begin errors++; $display("FAIL fault_sticky state=%0d fault=%b want 5 1", bus.state, bus.fault); end
        do_press;
        checks++; if (bus.state !== 3'd4 || bus.fault !== 1'b0) begin errors++; $display("FAIL fault_to_dead state=%0d fault=%b want 4 0", bus.state, bus.fault); end
        tick(3);
        checks++; if (bus.state !== 3'd3 || bus.open_ccw !== 1'b1 || bus.fault !== 1'b0) begin errors++; $display("FAIL fault_to_closing state=%0d ccw=%b fault=%b want 3 1 0", bus.state, bus.open_ccw, bus.fault); end
    endtask

    task automatic test_both_limits;
        bus.lim_open = 1'b1; bus.lim_closed = 1'b1;
        tick(1);
        bus.lim_open = 1'b0; bus.lim_closed = 1'b0;
        checks++; if (bus.state !== 3'd5 || bus.fault !== 1'b1 || bus.open_ccw !== 1'b0) begin errors++; $display("FAIL both_limits state=%0d fault=%b ccw=%b want 5 1 0", bus.state, bus.fault, bus.open_ccw); end
        tick(8);
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        do_press;
        checks++; if (bus.state !== 3'd1 || bus.open_cw !== 1'b1) begin errors++; $display("FAIL rst_mid_opening state=%0d cw=%b want 1 1", bus.state, bus.open_cw); end
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.state !== 3'd0 || bus.open_cw !== 1'b0) begin errors++; $display("FAIL async_reset state=%0d cw=%b want 0 0", bus.state, bus.open_cw); end
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_hold;
        do_press;
        bus.lim_open = 1'b1;
        tick(1);
        bus.lim_open = 1'b0;
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL hold_entry got %0d want 2", bus.state); end
`ifdef DOOR_AUTO_CLOSE_EN
        tick(31);
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL hold_last got %0d want 2", bus.state); end
        tick(1);
        checks++; if (bus.state !== 3'd3 || bus.open_ccw !== 1'b1) begin errors++; $display("FAIL auto_close state=%0d ccw=%b want 3 1", bus.state, bus.open_ccw); end
`else
        for (int i = 0; i < 200; i++) begin
            tick(1);
            checks++;
            if (bus.state !== 3'd2 || bus.open_cw !== 1'b0 || bus.open_ccw !== 1'b0) begin
                errors++; $display("FAIL hold_stay cyc%0d state=%0d cw=%b ccw=%b want 2 0 0", i, bus.state, bus.open_cw, bus.open_ccw);
            end
        end
`endif
    endtask

    initial begin
        test_reset;
        test_open_close;
        test_glitch;
        test_reverse;
        test_timeout;
        test_both_limits;
        test_reset_mid;
        test_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
